nnet_vector_framer: RTL and testbench
=====================================

Name: nnet_vector_framer

Overview:
- Parametrised successor to the fixed 16-bit neural-net vector wrapper; sits between axi_wrapper and an HLS nnet core inside a noc_block.
- Reframes arbitrary-length RFNoC packets into exact SIZE_IN-sample input vectors, zero-padding short packets and dropping excess samples.
- Re-frames HLS output, which carries no tlast, into SIZE_OUT-sample packets.
- Carries each input packet's tuser through a FIFO so multiple vectors can be in flight; exports pad/drop counters.

Parameters:
- WIDTH, 32, sample width on all data buses.
- SIZE_W, 16, width of the size registers and beat counters.
- TUSER_DEPTH_LOG2, 3, log2 of the tuser FIFO depth (8 entries).
- SR_SIZE_INPUT, 129, settings address of the input vector size.
- SR_SIZE_OUTPUT, 130, settings address of the output vector size.

Ports:
- clk  in  1  ce_clk domain clock.
- reset_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous flush (clear_tx_seqnum).
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- pkt_size_in  out  SIZE_W  active input vector size, to the HLS core.
- pkt_size_out  out  SIZE_W  active output vector size, to the HLS core.
- i_tdata  in  WIDTH  data from axi_wrapper.
- i_tlast  in  1  last beat of the input packet.
- i_tvalid  in  1  input data valid.
- i_tready  out  1  input ready.
- i_tuser  in  128  input packet header.
- o_tdata  out  WIDTH  data to axi_wrapper.
- o_tlast  out  1  last beat of the output packet.
- o_tvalid  out  1  output data valid.
- o_tready  in  1  downstream ready.
- o_tuser  out  128  output packet header.
- m_axis_tdata  out  WIDTH  vector samples to HLS.
- m_axis_tlast  out  1  last sample of the vector.
- m_axis_tvalid  out  1  sample valid, to HLS.
- m_axis_tready  in  1  HLS ready.
- s_axis_tdata  in  WIDTH  HLS result samples.
- s_axis_tvalid  in  1  HLS result valid.
- s_axis_tready  out  1  ready to HLS.
- pad_count  out  16  saturating count of padded beats.
- drop_count  out  16  saturating count of dropped beats.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All valids/readies 0; counters 0; FIFO empty; both FSMs idle.
  - Size registers load 1; pad_count/drop_count 0.
  - Same effect mid-packet: partial vectors are discarded.
- clear=1: same as reset except the size registers keep their values.
- Size registers:
  - Written when set_stb and set_addr matches; low SIZE_W bits taken.
  - A written value of 0 is stored as 1.
  - Active sizes (pkt_size_in/out) latch from the registers only when the respective FSM is at a vector boundary (count 0). A mid-vector write does not affect the current vector.
- Input FSM:
  - IN_IDLE: i_tready=0 while the FIFO is full. On an i_tvalid first beat with the FIFO not full, capture i_tuser, go to IN_DATA.
  - IN_DATA:
    - m_axis_tvalid = i_tvalid and m_axis_tdata = i_tdata (combinational pass-through); i_tready = m_axis_tready.
    - in_cnt increments on each transfer; m_axis_tlast = (in_cnt == size_in-1).
    - Last vector beat transferred: push captured tuser. If i_tlast was on that same beat, go to IN_IDLE; otherwise go to IN_DROP.
    - i_tlast before the vector is full: go to IN_PAD.
  - IN_PAD:
    - i_tready=0; m_axis_tvalid=1 with tdata=0 until in_cnt reaches size_in-1 (tlast on that beat).
    - pad_count +1 per padded beat. Push tuser, go to IN_IDLE.
  - IN_DROP:
    - i_tready=1; m_axis_tvalid=0; drop_count +1 per beat.
    - On i_tlast, go to IN_IDLE.
  - A push and a pop in the same cycle are both honoured; FIFO occupancy is unchanged.
- Output path:
  - s_axis_tready = o_tready AND FIFO not empty; o_tvalid = s_axis_tvalid AND FIFO not empty; o_tdata = s_axis_tdata.
  - o_tuser = FIFO head; out_cnt counts transfers; o_tlast = (out_cnt == size_out-1).
  - On the tlast transfer: pop FIFO, out_cnt returns to 0.
  - Zero added latency.
- Counters saturate at 16'hFFFF and never wrap.
- No assumption of valid-before-ready; tvalid never depends on tready for any output.

Test Plan:
- size_in=4, size_out=2, 4-beat packet 1..4 with tuser=T0, HLS loopback emitting 2 words → m_axis 1..4 with tlast on the 4th beat; o 2 beats, tlast on the 2nd, o_tuser=T0.
- size_in=4, 2-beat packet A,B → m_axis A,B,0,0 with tlast on the 4th beat; i_tready=0 during the pad beats; pad_count=2.
- size_in=4, 6-beat packet → m_axis carries the first 4 beats; 2 beats consumed with i_tready=1; drop_count=2; next packet aligns at in_cnt=0.
- 9 back-to-back packets with o_tready=0 → 8 tuser entries fill the FIFO; i_tready=0 at the 9th packet start; releasing o_tready drains the output in order T0..T8.
- Write size_in=8 mid-vector at size 4 → current vector ends at beat 4; next vector is 8 beats. Write 0 → active size becomes 1.
- Assert reset_n=0 mid-IN_PAD, then release → all outputs 0 and FIFO empty; a new packet frames correctly; counters read 0; sizes read 1.

Source files
------------

// File: rtl/nnet_vector_framer.sv
// rtl/nnet_vector_framer.sv - reframes RFNoC packets into fixed-size HLS vectors and back
// Input side pads/drops to SIZE_IN beats; output side cuts tlast-less HLS results into SIZE_OUT packets.
module nnet_vector_framer #(
  parameter int WIDTH            = 32,
  parameter int SIZE_W           = 16,
  parameter int TUSER_DEPTH_LOG2 = 3,
  parameter int SR_SIZE_INPUT    = 129,
  parameter int SR_SIZE_OUTPUT   = 130
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  output logic [SIZE_W-1:0] pkt_size_in,
  output logic [SIZE_W-1:0] pkt_size_out,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  input  logic [127:0]      i_tuser,
  output logic [WIDTH-1:0]  o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [127:0]      o_tuser,
  output logic [WIDTH-1:0]  m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [WIDTH-1:0]  s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [15:0]       pad_count,
  output logic [15:0]       drop_count
);

  localparam int DEPTH = 1 << TUSER_DEPTH_LOG2;

  typedef enum logic [1:0] {IN_IDLE, IN_DATA, IN_PAD, IN_DROP} in_state_t;
  in_state_t in_state, in_state_nxt;

  logic [SIZE_W-1:0] size_in_reg, size_out_reg, size_in_act, size_out_act;
  logic [SIZE_W-1:0] size_in_use, size_out_use;
  logic [SIZE_W-1:0] in_cnt, in_cnt_nxt, out_cnt;
  logic [SIZE_W-1:0] set_val;
  logic              set_data_unused;
  logic [127:0]      tuser_hold;
  logic [127:0]      fifo_mem [DEPTH];
  logic [TUSER_DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, push, pop;
  logic              in_last, pad_inc, drop_inc, o_xfer;

  assign set_val         = (set_data[SIZE_W-1:0] == '0) ? SIZE_W'(1) : set_data[SIZE_W-1:0];
  assign set_data_unused = ^set_data[31:SIZE_W];

  // At count 0 the register value is live, so a write lands on the next vector only.
  assign size_in_use  = (in_cnt == '0) ? size_in_reg : size_in_act;
  assign size_out_use = (out_cnt == '0) ? size_out_reg : size_out_act;
  assign pkt_size_in  = size_in_use;
  assign pkt_size_out = size_out_use;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      size_in_reg  <= SIZE_W'(1);
      size_out_reg <= SIZE_W'(1);
      size_in_act  <= SIZE_W'(1);
      size_out_act <= SIZE_W'(1);
    end else begin
      if (set_stb && set_addr == 8'(SR_SIZE_INPUT))  size_in_reg  <= set_val;
      if (set_stb && set_addr == 8'(SR_SIZE_OUTPUT)) size_out_reg <= set_val;
      if (in_cnt == '0)  size_in_act  <= size_in_reg;
      if (out_cnt == '0) size_out_act <= size_out_reg;
    end
  end

  assign in_last = (in_cnt == size_in_use - SIZE_W'(1));

  always_comb begin
    in_state_nxt  = in_state;
    in_cnt_nxt    = in_cnt;
    i_tready      = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    push          = 1'b0;
    pad_inc       = 1'b0;
    drop_inc      = 1'b0;
    case (in_state)
      IN_IDLE: begin
        if (i_tvalid && !fifo_full) in_state_nxt = IN_DATA;
      end
      IN_DATA: begin
        m_axis_tvalid = i_tvalid;
        m_axis_tdata  = i_tdata;
        m_axis_tlast  = in_last;
        i_tready      = m_axis_tready;
        if (i_tvalid && m_axis_tready) begin
          if (in_last) begin
            push         = 1'b1;
            in_cnt_nxt   = '0;
            in_state_nxt = i_tlast ? IN_IDLE : IN_DROP;
          end else begin
            in_cnt_nxt = in_cnt + SIZE_W'(1);
            if (i_tlast) in_state_nxt = IN_PAD;
          end
        end
      end
      IN_PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = in_last;
        if (m_axis_tready) begin
          pad_inc = 1'b1;
          if (in_last) begin
            push         = 1'b1;
            in_cnt_nxt   = '0;
            in_state_nxt = IN_IDLE;
          end else begin
            in_cnt_nxt = in_cnt + SIZE_W'(1);
          end
        end
      end
      IN_DROP: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          drop_inc = 1'b1;
          if (i_tlast) in_state_nxt = IN_IDLE;
        end
      end
      default: in_state_nxt = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      in_state   <= IN_IDLE;
      in_cnt     <= '0;
      tuser_hold <= '0;
      pad_count  <= '0;
      drop_count <= '0;
    end else begin
      in_state <= in_state_nxt;
      in_cnt   <= in_cnt_nxt;
      if (in_state == IN_IDLE && i_tvalid && !fifo_full) tuser_hold <= i_tuser;
      if (pad_inc && pad_count != 16'hFFFF)   pad_count  <= pad_count + 16'd1;
      if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  // Output path is purely combinational apart from the beat counter and tuser FIFO.
  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign fifo_full     = (wr_ptr[TUSER_DEPTH_LOG2] != rd_ptr[TUSER_DEPTH_LOG2]) &&
                         (wr_ptr[TUSER_DEPTH_LOG2-1:0] == rd_ptr[TUSER_DEPTH_LOG2-1:0]);
  assign s_axis_tready = o_tready && !fifo_empty;
  assign o_tvalid      = s_axis_tvalid && !fifo_empty;
  assign o_tdata       = s_axis_tdata;
  assign o_tuser       = fifo_empty ? '0 : fifo_mem[rd_ptr[TUSER_DEPTH_LOG2-1:0]];
  assign o_tlast       = (out_cnt == size_out_use - SIZE_W'(1));
  assign o_xfer        = o_tvalid && o_tready;
  assign pop           = o_xfer && o_tlast;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[TUSER_DEPTH_LOG2-1:0]] <= tuser_hold;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (o_xfer) out_cnt <= o_tlast ? '0 : out_cnt + SIZE_W'(1);
    end
  end

endmodule

// File: tb/tb_nnet_vector_framer.sv
// tb/tb_nnet_vector_framer.sv - directed checks of the vector framer
module tb_nnet_vector_framer;

  localparam logic [7:0] SR_IN  = 8'd129;
  localparam logic [7:0] SR_OUT = 8'd130;

  logic         clk = 1'b0;
  logic         reset_n, clear, set_stb;
  logic [7:0]   set_addr;
  logic [31:0]  set_data;
  logic [15:0]  pkt_size_in, pkt_size_out;
  logic [31:0]  i_tdata, o_tdata, m_axis_tdata, s_axis_tdata;
  logic         i_tlast, i_tvalid, i_tready;
  logic [127:0] i_tuser, o_tuser;
  logic         o_tlast, o_tvalid, o_tready;
  logic         m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic         s_axis_tvalid, s_axis_tready;
  logic [15:0]  pad_count, drop_count;

  int total = 0;
  int bad   = 0;

  logic [32:0]  m_q [$];
  logic [160:0] o_q [$];

  typedef struct {
    int           size_in;
    int           n;
    logic [31:0]  base;
    logic [127:0] tu;
    int           exp_pad;
    int           exp_drop;
  } vec_t;
  vec_t tbl [6];

  nnet_vector_framer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .pkt_size_in(pkt_size_in), .pkt_size_out(pkt_size_out),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tuser(i_tuser),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tuser(o_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .pad_count(pad_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) m_q.push_back({m_axis_tlast, m_axis_tdata});
    if (o_tvalid && o_tready) o_q.push_back({o_tuser, o_tlast, o_tdata});
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/missing want event", name);
  endtask

  function automatic logic [127:0] tu_of(input int k);
    return {32'hFEED_0000, 64'h0, 32'h7000 + 32'(k)};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_size(input logic [7:0] addr, input logic [31:0] val);
    set_stb = 1'b1; set_addr = addr; set_data = val;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input logic [127:0] tu);
    int wc;
    for (int b = 0; b < n; b++) begin
      i_tdata = base + 32'(b); i_tlast = (b == n - 1); i_tvalid = 1'b1; i_tuser = tu;
      wc = 0;
      @(negedge clk);
      while (!i_tready && wc < 300) begin wc++; @(negedge clk); end
      if (!i_tready) begin note_fail("send_pkt_handshake"); break; end
      @(posedge clk); #1;
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic hls_emit(input int n, input logic [31:0] base);
    int wc;
    for (int w = 0; w < n; w++) begin
      s_axis_tdata = base + 32'(w); s_axis_tvalid = 1'b1;
      wc = 0;
      @(negedge clk);
      while (!s_axis_tready && wc < 300) begin wc++; @(negedge clk); end
      if (!s_axis_tready) begin note_fail("hls_emit_handshake"); break; end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_m(input int n, input logic [31:0] base, input int nvalid);
    logic [32:0] got, exp;
    for (int i = 0; i < n; i++) begin
      exp = {(i == n - 1), (i < nvalid) ? base + 32'(i) : 32'h0};
      if (m_q.size() == 0) begin note_fail("m_missing"); break; end
      got = m_q.pop_front();
      chk("m_beat", 128'(got), 128'(exp));
    end
    chk("m_extra", 128'(m_q.size()), 128'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'd0);
    chk({tag, "_i_tready"}, 128'(i_tready), 128'd0);
    chk({tag, "_o_tvalid"}, 128'(o_tvalid), 128'd0);
    chk({tag, "_s_tready"}, 128'(s_axis_tready), 128'd0);
    chk({tag, "_pad"}, 128'(pad_count), 128'd0);
    chk({tag, "_drop"}, 128'(drop_count), 128'd0);
    chk({tag, "_size_in"}, 128'(pkt_size_in), 128'd1);
    chk({tag, "_size_out"}, 128'(pkt_size_out), 128'd1);
  endtask

  initial begin
    logic [160:0] og;
    tbl[0] = '{4, 4, 32'h0000_0001, 128'hBEEF0000_00000000_00000000_000000A0, 0, 0};
    tbl[1] = '{4, 2, 32'h0000_00A0, 128'hBEEF0000_00000000_00000000_000000A1, 2, 0};
    tbl[2] = '{4, 6, 32'h0000_0060, 128'hBEEF0000_00000000_00000000_000000A2, 2, 2};
    tbl[3] = '{3, 3, 32'h0000_0030, 128'hBEEF0000_00000000_00000000_000000A3, 2, 2};
    tbl[4] = '{1, 1, 32'h0000_0010, 128'hBEEF0000_00000000_00000000_000000A4, 2, 2};
    tbl[5] = '{2, 5, 32'h0000_0050, 128'hBEEF0000_00000000_00000000_000000A5, 2, 5};

    reset_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; i_tuser = '0;
    o_tready = 1'b1; m_axis_tready = 1'b1; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;

    // Table-driven framing: one packet per row, followed by a 2-word HLS result.
    set_size(SR_OUT, 32'd2);
    for (int e = 0; e < 6; e++) begin
      set_size(SR_IN, 32'(tbl[e].size_in));
      m_q.delete(); o_q.delete();
      send_pkt(tbl[e].n, tbl[e].base, tbl[e].tu);
      wait_cycles(8);
      check_m(tbl[e].size_in, tbl[e].base, (tbl[e].n < tbl[e].size_in) ? tbl[e].n : tbl[e].size_in);
      hls_emit(2, tbl[e].base + 32'h100);
      for (int j = 0; j < 2; j++) begin
        if (o_q.size() == 0) begin note_fail("o_missing"); break; end
        og = o_q.pop_front();
        chk("o_beat", 128'(og[32:0]), 128'({(j == 1), tbl[e].base + 32'h100 + 32'(j)}));
        chk("o_tuser", og[160:33], tbl[e].tu);
      end
      chk("pad_count", 128'(pad_count), 128'(tbl[e].exp_pad));
      chk("drop_count", 128'(drop_count), 128'(tbl[e].exp_drop));
    end

    // Fill the tuser FIFO, confirm the 9th packet stalls, then drain in order.
    o_tready = 1'b0;
    set_size(SR_IN, 32'd1);
    set_size(SR_OUT, 32'd1);
    m_q.delete(); o_q.delete();
    for (int k = 0; k < 8; k++) send_pkt(1, 32'h200 + 32'(k), tu_of(k));
    i_tdata = 32'h208; i_tuser = tu_of(8); i_tlast = 1'b1; i_tvalid = 1'b1;
    wait_cycles(4);
    @(negedge clk);
    chk("full_i_tready", 128'(i_tready), 128'd0);
    chk("full_m_tvalid", 128'(m_axis_tvalid), 128'd0);
    @(posedge clk); #1;
    o_tready = 1'b1;
    fork
      send_pkt(1, 32'h208, tu_of(8));
      hls_emit(9, 32'h300);
    join
    wait_cycles(2);
    chk("fill_m_count", 128'(m_q.size()), 128'd9);
    for (int k = 0; k < 9; k++) begin
      if (o_q.size() == 0) begin note_fail("fill_o_missing"); break; end
      og = o_q.pop_front();
      chk("fill_o_tuser", og[160:33], tu_of(k));
      chk("fill_o_beat", 128'(og[32:0]), 128'({1'b1, 32'h300 + 32'(k)}));
    end

    // Size write mid-vector applies to the following vector only.
    set_size(SR_IN, 32'd4);
    m_q.delete();
    fork
      send_pkt(12, 32'h400, tu_of(20));
      begin
        repeat (2) @(posedge clk);
        #1;
        set_size(SR_IN, 32'd8);
      end
    join
    wait_cycles(3);
    check_m(4, 32'h400, 4);
    chk("mid_drop", 128'(drop_count), 128'd13);
    chk("mid_size_next", 128'(pkt_size_in), 128'd8);
    send_pkt(8, 32'h500, tu_of(21));
    wait_cycles(3);
    check_m(8, 32'h500, 8);
    set_size(SR_IN, 32'd0);
    chk("zero_size_in", 128'(pkt_size_in), 128'd1);
    set_size(SR_OUT, 32'd0);
    chk("zero_size_out", 128'(pkt_size_out), 128'd1);

    // Pad beats hold off the input.
    set_size(SR_IN, 32'd4);
    m_q.delete();
    send_pkt(2, 32'hB0, tu_of(22));
    @(negedge clk);
    chk("pad_i_tready", 128'(i_tready), 128'd0);
    chk("pad_m_beat", 128'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 128'({1'b1, 1'b0, 32'h0}));
    @(negedge clk);
    chk("pad_i_tready_last", 128'(i_tready), 128'd0);
    chk("pad_m_tlast", 128'({m_axis_tvalid, m_axis_tlast}), 128'(2'b11));
    wait_cycles(3);
    chk("pad_count_hand", 128'(pad_count), 128'd4);
    check_m(4, 32'hB0, 2);

    // Reset while padding discards everything and restores defaults.
    set_size(SR_IN, 32'd8);
    send_pkt(1, 32'hC0, tu_of(23));
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check_reset_state("midpad");
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    m_q.delete();
    send_pkt(1, 32'hD0, tu_of(24));
    wait_cycles(3);
    check_m(1, 32'hD0, 1);

    // Clear flushes like reset but keeps the programmed sizes.
    set_size(SR_IN, 32'd3);
    send_pkt(1, 32'hE0, tu_of(25));
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    chk("clear_m_tvalid", 128'(m_axis_tvalid), 128'd0);
    chk("clear_pad", 128'(pad_count), 128'd0);
    chk("clear_size_in", 128'(pkt_size_in), 128'd3);
    @(posedge clk); #1;
    m_q.delete();
    send_pkt(3, 32'hF0, tu_of(26));
    wait_cycles(3);
    check_m(3, 32'hF0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
